// File: rtl/aes_sbox_share_ctrl.sv
// Shares one WIDTH-bit S-box bank between a 4-column state SubBytes job and a
// single-word key SubWord job, one column or word per cycle.
module aes_sbox_share_ctrl #(
  parameter int WIDTH        = 32,
  parameter bit KEY_PRIORITY = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_req_valid,
  output logic               st_req_ready,
  input  logic               st_mode,
  input  logic [4*WIDTH-1:0] st_in,
  output logic               st_rsp_valid,
  input  logic               st_rsp_ready,
  output logic [4*WIDTH-1:0] st_rsp_data,
  input  logic               ks_req_valid,
  output logic               ks_req_ready,
  input  logic [WIDTH-1:0]   ks_in,
  output logic               ks_rsp_valid,
  input  logic               ks_rsp_ready,
  output logic [WIDTH-1:0]   ks_rsp_data,
  output logic               sb_mode,
  output logic [WIDTH-1:0]   sb_in,
  input  logic [WIDTH-1:0]   sb_out,
  output logic               busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    RESP  = 2'd2
  } job_state_e;

  job_state_e           st_state_q, st_state_d;
  job_state_e           ks_state_q, ks_state_d;
  logic [4*WIDTH-1:0]   st_buf_q, st_buf_d;
  logic                 st_mode_q, st_mode_d;
  logic [1:0]           col_cnt_q, col_cnt_d;
  logic [WIDTH-1:0]     ks_buf_q, ks_buf_d;
  logic                 key_grant;
  logic                 st_grant;

  // With KEY_PRIORITY=0 the key waits until no state job is running.
  assign key_grant = (ks_state_q == RUN) && (KEY_PRIORITY || (st_state_q != RUN));
  assign st_grant  = !key_grant && (st_state_q == RUN);

  always_comb begin
    sb_in   = '0;
    sb_mode = 1'b0;
    if (key_grant) begin
      sb_in = ks_buf_q;
    end else if (st_grant) begin
      sb_in   = st_buf_q[32'(col_cnt_q)*WIDTH +: WIDTH];
      sb_mode = st_mode_q;
    end
  end

  // Results are written back in place over the captured input.
  always_comb begin
    st_state_d = st_state_q;
    st_buf_d   = st_buf_q;
    st_mode_d  = st_mode_q;
    col_cnt_d  = col_cnt_q;
    case (st_state_q)
      EMPTY: begin
        if (st_req_valid) begin
          st_buf_d   = st_in;
          st_mode_d  = st_mode;
          col_cnt_d  = 2'd0;
          st_state_d = RUN;
        end
      end
      RUN: begin
        if (st_grant) begin
          st_buf_d[32'(col_cnt_q)*WIDTH +: WIDTH] = sb_out;
          col_cnt_d = col_cnt_q + 2'd1;
          if (col_cnt_q == 2'd3) st_state_d = RESP;
        end
      end
      RESP: begin
        if (st_rsp_ready) st_state_d = EMPTY;
      end
      default: st_state_d = EMPTY;
    endcase
  end

  always_comb begin
    ks_state_d = ks_state_q;
    ks_buf_d   = ks_buf_q;
    case (ks_state_q)
      EMPTY: begin
        if (ks_req_valid) begin
          ks_buf_d   = ks_in;
          ks_state_d = RUN;
        end
      end
      RUN: begin
        if (key_grant) begin
          ks_buf_d   = sb_out;
          ks_state_d = RESP;
        end
      end
      RESP: begin
        if (ks_rsp_ready) ks_state_d = EMPTY;
      end
      default: ks_state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_state_q <= EMPTY;
      ks_state_q <= EMPTY;
      st_buf_q   <= '0;
      st_mode_q  <= 1'b0;
      col_cnt_q  <= 2'd0;
      ks_buf_q   <= '0;
    end else begin
      st_state_q <= st_state_d;
      ks_state_q <= ks_state_d;
      st_buf_q   <= st_buf_d;
      st_mode_q  <= st_mode_d;
      col_cnt_q  <= col_cnt_d;
      ks_buf_q   <= ks_buf_d;
    end
  end

  assign st_req_ready = (st_state_q == EMPTY);
  assign ks_req_ready = (ks_state_q == EMPTY);
  assign st_rsp_valid = (st_state_q == RESP);
  assign ks_rsp_valid = (ks_state_q == RESP);
  assign st_rsp_data  = st_buf_q;
  assign ks_rsp_data  = ks_buf_q;
  assign busy         = (st_state_q != EMPTY) || (ks_state_q != EMPTY);

endmodule

// File: tb/tb_aes_sbox_share_ctrl.sv
// Directed bench for aes_sbox_share_ctrl: instance a uses KEY_PRIORITY=1,
// instance b uses KEY_PRIORITY=0; each drives a reference AES S-box bank.
module tb_aes_sbox_share_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         st_req_valid_a, st_req_ready_a, st_mode_a, st_rsp_valid_a, st_rsp_ready_a;
  logic [127:0] st_in_a, st_rsp_data_a;
  logic         ks_req_valid_a, ks_req_ready_a, ks_rsp_valid_a, ks_rsp_ready_a;
  logic [31:0]  ks_in_a, ks_rsp_data_a, sb_in_a, sb_out_a;
  logic         sb_mode_a, busy_a;

  logic         st_req_valid_b, st_req_ready_b, st_mode_b, st_rsp_valid_b, st_rsp_ready_b;
  logic [127:0] st_in_b, st_rsp_data_b;
  logic         ks_req_valid_b, ks_req_ready_b, ks_rsp_valid_b, ks_rsp_ready_b;
  logic [31:0]  ks_in_b, ks_rsp_data_b, sb_in_b, sb_out_b;
  logic         sb_mode_b, busy_b;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];
  logic       tbl_ok = 1'b0;

  int tests = 0;
  int fails = 0;

  aes_sbox_share_ctrl #(.WIDTH(32), .KEY_PRIORITY(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .st_req_valid(st_req_valid_a), .st_req_ready(st_req_ready_a), .st_mode(st_mode_a),
    .st_in(st_in_a), .st_rsp_valid(st_rsp_valid_a), .st_rsp_ready(st_rsp_ready_a),
    .st_rsp_data(st_rsp_data_a),
    .ks_req_valid(ks_req_valid_a), .ks_req_ready(ks_req_ready_a), .ks_in(ks_in_a),
    .ks_rsp_valid(ks_rsp_valid_a), .ks_rsp_ready(ks_rsp_ready_a), .ks_rsp_data(ks_rsp_data_a),
    .sb_mode(sb_mode_a), .sb_in(sb_in_a), .sb_out(sb_out_a), .busy(busy_a)
  );

  aes_sbox_share_ctrl #(.WIDTH(32), .KEY_PRIORITY(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .st_req_valid(st_req_valid_b), .st_req_ready(st_req_ready_b), .st_mode(st_mode_b),
    .st_in(st_in_b), .st_rsp_valid(st_rsp_valid_b), .st_rsp_ready(st_rsp_ready_b),
    .st_rsp_data(st_rsp_data_b),
    .ks_req_valid(ks_req_valid_b), .ks_req_ready(ks_req_ready_b), .ks_in(ks_in_b),
    .ks_rsp_valid(ks_rsp_valid_b), .ks_rsp_ready(ks_rsp_ready_b), .ks_rsp_data(ks_rsp_data_b),
    .sb_mode(sb_mode_b), .sb_in(sb_in_b), .sb_out(sb_out_b), .busy(busy_b)
  );

  always_comb begin
    sb_out_a = '0;
    if (tbl_ok)
      for (int i = 0; i < 4; i++)
        sb_out_a[8*i +: 8] = sb_mode_a ? isbox_t[sb_in_a[8*i +: 8]] : sbox_t[sb_in_a[8*i +: 8]];
  end

  always_comb begin
    sb_out_b = '0;
    if (tbl_ok)
      for (int i = 0; i < 4; i++)
        sb_out_b[8*i +: 8] = sb_mode_b ? isbox_t[sb_in_b[8*i +: 8]] : sbox_t[sb_in_b[8*i +: 8]];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++;
    if ({st_req_ready_a, ks_req_ready_a, st_rsp_valid_a, ks_rsp_valid_a, busy_a} !== 5'b11000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 11000",
               {st_req_ready_a, ks_req_ready_a, st_rsp_valid_a, ks_rsp_valid_a, busy_a});
    end
    tests++;
    if ({st_rsp_data_a, ks_rsp_data_a, sb_in_a, sb_mode_a} !== '0) begin
      fails++;
      $display("FAIL reset_data: st=%h ks=%h sb_in=%h sb_mode=%b required all zero",
               st_rsp_data_a, ks_rsp_data_a, sb_in_a, sb_mode_a);
    end
    tests++;
    if ({st_req_ready_b, ks_req_ready_b, busy_b} !== 3'b110) begin
      fails++;
      $display("FAIL reset_b: got %b required 110", {st_req_ready_b, ks_req_ready_b, busy_b});
    end
  endtask

  task automatic test_encrypt();
    st_rsp_ready_a = 1'b1;
    st_in_a = {16{8'h53}};
    st_mode_a = 1'b0;
    st_req_valid_a = 1'b1;
    tests++;
    if (st_req_ready_a !== 1'b1) begin
      fails++;
      $display("FAIL enc_req_ready: got %b required 1", st_req_ready_a);
    end
    tick();
    st_req_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({st_rsp_valid_a, sb_mode_a, sb_in_a} !== {2'b00, 32'h53535353}) begin
        fails++;
        $display("FAIL enc_pass%0d: valid=%b mode=%b sb_in=%h required 0 0 53535353",
                 k, st_rsp_valid_a, sb_mode_a, sb_in_a);
      end
      tick();
    end
    tests++;
    if ({st_rsp_valid_a, st_rsp_data_a} !== {1'b1, {16{8'hED}}}) begin
      fails++;
      $display("FAIL enc_result: valid=%b data=%h required 1 %h", st_rsp_valid_a, st_rsp_data_a, {16{8'hED}});
    end
    tick();
    tests++;
    if ({st_req_ready_a, st_rsp_valid_a, busy_a} !== 3'b100) begin
      fails++;
      $display("FAIL enc_release: ready/valid/busy=%b required 100", {st_req_ready_a, st_rsp_valid_a, busy_a});
    end
  endtask

  task automatic test_column_order();
    logic [31:0] exp_col [4];
    exp_col[0] = 32'h03020100; exp_col[1] = 32'h07060504;
    exp_col[2] = 32'h0B0A0908; exp_col[3] = 32'h0F0E0D0C;
    st_in_a = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    st_mode_a = 1'b0;
    st_req_valid_a = 1'b1;
    tick();
    st_req_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (sb_in_a !== exp_col[k]) begin
        fails++;
        $display("FAIL order_col%0d: sb_in=%h required %h", k, sb_in_a, exp_col[k]);
      end
      tick();
    end
    tests++;
    if ({st_rsp_valid_a, st_rsp_data_a} !== {1'b1, 128'h76ABD7FE_2B670130_C56F6BF2_7B777C63}) begin
      fails++;
      $display("FAIL order_result: valid=%b data=%h required 1 76abd7fe2b670130c56f6bf27b777c63",
               st_rsp_valid_a, st_rsp_data_a);
    end
    tick();
  endtask

  task automatic test_decrypt();
    st_in_a = {16{8'h63}};
    st_mode_a = 1'b1;
    st_req_valid_a = 1'b1;
    tick();
    st_req_valid_a = 1'b0;
    st_mode_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({st_rsp_valid_a, sb_mode_a, sb_in_a} !== {2'b01, 32'h63636363}) begin
        fails++;
        $display("FAIL dec_pass%0d: valid=%b mode=%b sb_in=%h required 0 1 63636363",
                 k, st_rsp_valid_a, sb_mode_a, sb_in_a);
      end
      tick();
    end
    tests++;
    if ({st_rsp_valid_a, st_rsp_data_a} !== {1'b1, 128'h0}) begin
      fails++;
      $display("FAIL dec_result: valid=%b data=%h required 1 0", st_rsp_valid_a, st_rsp_data_a);
    end
    tick();
  endtask

  task automatic test_preempt();
    ks_rsp_ready_a = 1'b1;
    st_in_a = 128'h0;
    st_mode_a = 1'b0;
    st_req_valid_a = 1'b1;
    tick();
    st_req_valid_a = 1'b0;
    ks_in_a = 32'h00010053;
    ks_req_valid_a = 1'b1;
    tick();
    ks_req_valid_a = 1'b0;
    tests++;
    if ({sb_mode_a, sb_in_a, st_rsp_valid_a} !== {1'b0, 32'h00010053, 1'b0}) begin
      fails++;
      $display("FAIL pre_key_grant: mode=%b sb_in=%h stv=%b required 0 00010053 0",
               sb_mode_a, sb_in_a, st_rsp_valid_a);
    end
    tick();
    tests++;
    if ({ks_rsp_valid_a, ks_rsp_data_a} !== {1'b1, 32'h637C63ED}) begin
      fails++;
      $display("FAIL pre_key_result: valid=%b data=%h required 1 637c63ed", ks_rsp_valid_a, ks_rsp_data_a);
    end
    tick();
    tests++;
    if ({ks_rsp_valid_a, ks_req_ready_a, st_rsp_valid_a} !== 3'b010) begin
      fails++;
      $display("FAIL pre_key_release: ksv/ksr/stv=%b required 010", {ks_rsp_valid_a, ks_req_ready_a, st_rsp_valid_a});
    end
    tick();
    tests++;
    if (st_rsp_valid_a !== 1'b0) begin
      fails++;
      $display("FAIL pre_state_early: valid=%b required 0 at T0+4", st_rsp_valid_a);
    end
    tick();
    tests++;
    if ({st_rsp_valid_a, st_rsp_data_a} !== {1'b1, {16{8'h63}}}) begin
      fails++;
      $display("FAIL pre_state_result: valid=%b data=%h required 1 %h", st_rsp_valid_a, st_rsp_data_a, {16{8'h63}});
    end
    tick();
  endtask

  task automatic test_no_priority();
    st_rsp_ready_b = 1'b1;
    ks_rsp_ready_b = 1'b1;
    st_in_b = {16{8'h53}};
    st_mode_b = 1'b0;
    ks_in_b = 32'h00010053;
    st_req_valid_b = 1'b1;
    ks_req_valid_b = 1'b1;
    tick();
    st_req_valid_b = 1'b0;
    ks_req_valid_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({ks_rsp_valid_b, st_rsp_valid_b, sb_in_b} !== {2'b00, 32'h53535353}) begin
        fails++;
        $display("FAIL kp0_pass%0d: ksv=%b stv=%b sb_in=%h required 0 0 53535353",
                 k, ks_rsp_valid_b, st_rsp_valid_b, sb_in_b);
      end
      tick();
    end
    tests++;
    if ({st_rsp_valid_b, st_rsp_data_b, ks_rsp_valid_b, sb_in_b} !== {1'b1, {16{8'hED}}, 1'b0, 32'h00010053}) begin
      fails++;
      $display("FAIL kp0_state_done: stv=%b data=%h ksv=%b sb_in=%h required 1 all-ed 0 00010053",
               st_rsp_valid_b, st_rsp_data_b, ks_rsp_valid_b, sb_in_b);
    end
    tick();
    tests++;
    if ({ks_rsp_valid_b, ks_rsp_data_b, st_rsp_valid_b} !== {1'b1, 32'h637C63ED, 1'b0}) begin
      fails++;
      $display("FAIL kp0_key_done: ksv=%b data=%h stv=%b required 1 637c63ed 0",
               ks_rsp_valid_b, ks_rsp_data_b, st_rsp_valid_b);
    end
    tick();
    tests++;
    if (busy_b !== 1'b0) begin
      fails++;
      $display("FAIL kp0_idle: busy=%b required 0", busy_b);
    end
  endtask

  task automatic test_backpressure();
    st_rsp_ready_a = 1'b0;
    st_in_a = {16{8'h53}};
    st_mode_a = 1'b0;
    st_req_valid_a = 1'b1;
    tick();
    st_req_valid_a = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      tests++;
      if ({st_rsp_valid_a, st_rsp_data_a, st_req_ready_a, busy_a} !== {1'b1, {16{8'hED}}, 2'b01}) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b busy=%b required 1 all-ed 0 1",
                 k, st_rsp_valid_a, st_rsp_data_a, st_req_ready_a, busy_a);
      end
      tick();
    end
    st_rsp_ready_a = 1'b1;
    tests++;
    if ({st_rsp_valid_a, st_req_ready_a} !== 2'b10) begin
      fails++;
      $display("FAIL bp_handshake_cycle: valid/ready=%b required 10", {st_rsp_valid_a, st_req_ready_a});
    end
    tick();
    tests++;
    if ({st_rsp_valid_a, st_req_ready_a, busy_a} !== 3'b010) begin
      fails++;
      $display("FAIL bp_release: valid/ready/busy=%b required 010", {st_rsp_valid_a, st_req_ready_a, busy_a});
    end
  endtask

  task automatic test_reset_mid();
    st_rsp_ready_a = 1'b1;
    st_in_a = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    st_mode_a = 1'b0;
    st_req_valid_a = 1'b1;
    tick();
    st_req_valid_a = 1'b0;
    tick();
    tick();
    tests++;
    if (sb_in_a !== 32'h0B0A0908) begin
      fails++;
      $display("FAIL rst_col2: sb_in=%h required 0b0a0908", sb_in_a);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({st_rsp_valid_a, ks_rsp_valid_a, st_req_ready_a, ks_req_ready_a, busy_a} !== 5'b00110) begin
      fails++;
      $display("FAIL rst_immediate: stv/ksv/str/ksr/busy=%b required 00110",
               {st_rsp_valid_a, ks_rsp_valid_a, st_req_ready_a, ks_req_ready_a, busy_a});
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tests++;
      if ({st_rsp_valid_a, busy_a} !== 2'b00) begin
        fails++;
        $display("FAIL rst_no_rsp%0d: valid/busy=%b required 00", k, {st_rsp_valid_a, busy_a});
      end
      tick();
    end
    st_req_valid_a = 1'b1;
    tick();
    st_req_valid_a = 1'b0;
    repeat (3) tick();
    tests++;
    if (st_rsp_valid_a !== 1'b0) begin
      fails++;
      $display("FAIL rst_new_early: valid=%b required 0 after 3 cycles", st_rsp_valid_a);
    end
    tick();
    tests++;
    if ({st_rsp_valid_a, st_rsp_data_a} !== {1'b1, 128'h76ABD7FE_2B670130_C56F6BF2_7B777C63}) begin
      fails++;
      $display("FAIL rst_new_result: valid=%b data=%h required 1 76abd7fe2b670130c56f6bf27b777c63",
               st_rsp_valid_a, st_rsp_data_a);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
    tbl_ok = 1'b1;

    st_req_valid_a = 0; st_mode_a = 0; st_in_a = '0; st_rsp_ready_a = 0;
    ks_req_valid_a = 0; ks_in_a = '0; ks_rsp_ready_a = 0;
    st_req_valid_b = 0; st_mode_b = 0; st_in_b = '0; st_rsp_ready_b = 0;
    ks_req_valid_b = 0; ks_in_b = '0; ks_rsp_ready_b = 0;
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();

    test_encrypt();
    test_column_order();
    test_decrypt();
    test_preempt();
    test_no_priority();
    test_backpressure();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_sbox_share_ctrl.md
Name: aes_sbox_share_ctrl

Overview:
- Time-multiplexed scheduler for one external 32-bit S-box bank (four AES S-boxes, combinational, mode-selectable).
- Two requesters share the bank: the round datapath, which needs a 128-bit SubBytes/InvSubBytes done as 4 column passes, and key expansion, which needs a 32-bit SubWord (always forward).
- Sits between the round controller, the key schedule and the shared S-box bank. Replaces a 16-S-box SubBytes array in area-constrained builds.

Parameters:
- WIDTH, 32, column width in bits; the bank processes one column per cycle. The state width is 4*WIDTH.
- KEY_PRIORITY, 1, 1 = a pending key request wins the bank at any column boundary; 0 = a state job in progress runs to completion first.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- st_req_valid  in  1  state job request
- st_req_ready  out  1  state buffer free
- st_mode  in  1  0 = SubBytes, 1 = InvSubBytes; captured at accept
- st_in  in  4*WIDTH  state; [WIDTH-1:0] = column 0 ... [4*WIDTH-1:3*WIDTH] = column 3
- st_rsp_valid  out  1  state result valid
- st_rsp_ready  in  1  state result consumed
- st_rsp_data  out  4*WIDTH  substituted state, same column order
- ks_req_valid  in  1  SubWord request
- ks_req_ready  out  1  key buffer free
- ks_in  in  WIDTH  word to substitute
- ks_rsp_valid  out  1  key result valid
- ks_rsp_ready  in  1  key result consumed
- ks_rsp_data  out  WIDTH  SubWord result
- sb_mode  out  1  bank mode
- sb_in  out  WIDTH  bank input
- sb_out  in  WIDTH  bank output, combinational from sb_in in the same cycle
- busy  out  1  any job pending or any response held

Behaviour:
- Reset (async assert): all valids 0, all data registers 0, col_cnt 0, both buffers empty, busy 0. Readies are combinational from the buffer-empty flags, so they read 1 out of reset.
- Reset mid-operation: in-flight jobs are discarded and no response is issued.
- Handshake: a transfer occurs when valid && ready at a rising edge.
  - req_ready = buffer empty. It has no same-cycle dependency on the response handshake.
  - A buffer frees on its rsp handshake edge, and ready rises the following cycle.
- State FSM, per buffer:
  - EMPTY -> (accept) RUN -> (column 3 written) RESP -> (rsp handshake) EMPTY.
  - At accept, st_in and st_mode are captured and col_cnt is set to 0.
- Key FSM: EMPTY -> (accept) RUN -> (bank granted) RESP -> (rsp handshake) EMPTY.
- Per-cycle grant:
  - Key grant: taken when key is in RUN and (KEY_PRIORITY=1, or state is not in RUN). Drives sb_in = ks_buf and sb_mode = 0. At the next edge ks_rsp_data <= sb_out and ks_rsp_valid <= 1.
  - State grant: taken otherwise, if state is in RUN. Drives sb_in = column col_cnt and sb_mode = captured mode. At the next edge that result column <= sb_out and col_cnt++. After column 3, col_cnt wraps to 0 and st_rsp_valid <= 1.
  - No grant: sb_in = 0, sb_mode = 0.
- Latency from the accept edge, uncontended:
  - State: 4 cycles (st_rsp_valid high after the 4th edge).
  - Key: 1 cycle.
  - Each key grant taken during a state job adds 1 cycle to that job.
- Starvation bound: a key job occupies the bank for exactly 1 cycle and cannot be re-accepted until its response is consumed plus one cycle. The state job therefore advances at least every second cycle.
- Simultaneous accepts in the same cycle are legal; the grant rules above apply from the next cycle.
- Backpressure: rsp_data and rsp_valid hold stable while rsp_ready = 0. A job in RESP never requests the bank.
- busy = state not EMPTY or key not EMPTY.

Test Plan:
- Bench bank model: reference AES S-box/inverse S-box per byte.
- 1. Encrypt: st_in = all bytes 0x53, st_mode = 0, rsp_ready = 1.
  -> st_rsp_valid exactly 4 cycles after accept, st_rsp_data = all bytes 0xED.
  -> sb_in shows columns 0, 1, 2, 3 in order.
- 2. Decrypt: st_in = all bytes 0x63, st_mode = 1.
  -> st_rsp_data = all zero after 4 cycles.
  -> sb_mode = 1 during all 4 column passes.
- 3. Preemption, KEY_PRIORITY = 1: state accept at T0 (all 0x00), ks_in = 0x00010053 accepted at T1.
  -> ks_rsp_data = 0x637C63ED at T2.
  -> state result = all 0x63, valid at T0+5.
- 4. KEY_PRIORITY = 0: both requests accepted in the same cycle.
  -> state result after 4 cycles, key result after 5 cycles.
- 5. Backpressure: hold st_rsp_ready = 0 for 10 cycles.
  -> data stable, st_req_ready = 0, busy = 1.
  -> after the handshake, st_req_ready = 1 the next cycle.
- 6. Assert rst during column 2 of a state job.
  -> valids 0 immediately, readies 1, no response after release.
  -> a new job then completes normally in 4 cycles.
